bcd_calendar_counter: RTL and testbench
=======================================

Name: bcd_calendar_counter

Overview:
Timekeeping core of the millennium clock, directly upstream of the seven-segment display stage. It divides the board clock to a 1 Hz tick and keeps packed-BCD seconds, minutes, hours, day, month and 4-digit year with full Gregorian leap rules. It also runs the user set-mode state machine and drives the view select, set-mode flag and blinking-field index that the display stage consumes.

Parameters:
CLK_HZ, 50000000, board clock frequency; one second = CLK_HZ cycles (benches use 4)
RST_YEAR, 16'h2000, year loaded at reset (packed BCD)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_view  in  1  one-cycle debounced pulse; toggles smh_dmy
btn_mode  in  1  one-cycle pulse; toggles dem_chinh (run/set)
btn_sel  in  1  one-cycle pulse; advances blink_led in set mode
btn_inc  in  1  one-cycle pulse; increments selected field in set mode
smh_dmy  out  1  0 = time view, 1 = date view
dem_chinh  out  1  1 = set mode
blink_led  out  2  selected field: 00, 01, 10
bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo  out  8 each  packed BCD, tens in [7:4]
bcd_yyyy  out  16  packed BCD, thousands in [15:12]

Interface clocking: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: 00:00:00, dd=01, mo=01, yyyy=RST_YEAR, smh_dmy=0, dem_chinh=0, blink_led=00, prescaler=0. All outputs registered.
- Prescaler: counts 0..CLK_HZ-1; tick asserted for one cycle at CLK_HZ-1, then wraps to 0. The prescaler is held at 0 while dem_chinh=1.
- Run mode: on tick, ss increments; ss 59->00 carries to mm; mm 59->00 carries to hh; hh 23->00 carries to dd; dd at days_in_month->01 carries to mo; mo 12->01 carries to yyyy; yyyy 9999->0000. The full carry chain resolves in one cycle. Outputs change the cycle after the tick.
- days_in_month: 31/30 per month; Feb = 29 if leap, else 28. Leap rule: year divisible by 4 and not by 100, or divisible by 400. This is evaluated on BCD digits: a two-digit pair is divisible by 4 iff (tens even and ones in {0,4,8}) or (tens odd and ones in {2,6}).
- FSM states:
  - RUN: btn_mode -> SET, with blink_led=00.
  - SET: btn_mode -> RUN, with prescaler restarting from 0. btn_sel steps blink_led 00->01->10->00.
- Set-mode field map:
  - smh_dmy=0: 00=ss, 01=mm, 10=hh.
  - smh_dmy=1: 00=yyyy, 01=mo, 10=dd.
- btn_inc increments the selected field by 1 with wrap and no carry:
  - ss/mm: 59->00; hh: 23->00.
  - dd: max->01; mo: 12->01; yyyy: 9999->0000.
  - Setting ss also clears nothing else.
- Day clamp: after any mo or yyyy change (set or carry), if dd exceeds the new days_in_month, dd is clamped to that maximum in the same cycle (e.g. 31/03 with mo inc -> 30/04).
- Priority in one cycle:
  - btn_mode > btn_sel > btn_inc; lower-priority pulses in that cycle are dropped.
  - btn_view always acts, in any mode.
  - A tick coinciding with btn_mode entering SET is dropped.
- blink_led never takes 11. btn_sel and btn_inc are ignored in RUN.
- Reset asserted mid-edit returns to RUN with reset values.

Optional Feature:
BTN_DEC_EN
- Defined: adds input port btn_dec (1-bit pulse), which decrements the selected field with the mirror wraps (00->59, 00->23, 01->max day, 01->12, 0000->9999). Day clamp applies. Priority is btn_inc > btn_dec.
- Undefined: port absent, behaviour as above.

Decomposition:
- Package cal_pkg holds:
  - field index constants FLD_0/1/2;
  - BCD limits (8'h59, 8'h23, 8'h12);
  - reset constants;
  - functions bcd_inc_wrap, bcd_is_leap, days_in_month (returns packed BCD 8'h28..8'h31).
- One sub-module, sec_tick_gen: the CLK_HZ prescaler with clear input and one-cycle tick output.
- Counter chain and FSM stay in the top.

Test Plan:
- Reset, CLK_HZ=4, run 8 cycles -> bcd_ss=8'h02, mm=00, hh=00, date 01/01/2000.
- Preload 23:59:59 31/12/2099 via set mode, then exit and wait one tick -> 00:00:00 01/01/2100.
- Date 28/02/1900, one day of ticks -> 01/03/1900. Date 28/02/2000 -> 29/02/2000. Date 28/02/2024 -> 29/02/2024.
- Set mode, smh_dmy=1, dd=31, mo=01, blink_led=01, btn_inc -> mo=02, dd clamps to 28 (yyyy=2023) or 29 (yyyy=2024).
- Same-cycle btn_mode+btn_inc in RUN -> dem_chinh=1, all fields unchanged. btn_sel three times -> blink_led 01, 10, 00.
- In SET, hold 3*CLK_HZ cycles -> bcd_ss unchanged. Exit -> first increment exactly CLK_HZ cycles later.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared constants, FSM state type and packed-BCD helpers for the calendar counter.
package cal_pkg;

    typedef enum logic {StRun = 1'b0, StSet = 1'b1} mode_e;

    localparam logic [1:0] FLD_0 = 2'b00;
    localparam logic [1:0] FLD_1 = 2'b01;
    localparam logic [1:0] FLD_2 = 2'b10;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MON_MAX  = 8'h12;

    localparam logic [7:0] RST_TIME = 8'h00;
    localparam logic [7:0] RST_DATE = 8'h01;

    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] max,
                                                input logic [7:0] min);
        if (v == max) return min;
        if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
        return v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec_wrap(input logic [7:0] v, input logic [7:0] max,
                                                input logic [7:0] min);
        if (v == min) return max;
        if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
        return v - 8'h01;
    endfunction

    function automatic logic [15:0] bcd16_inc(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'h9) r[4*i +: 4] = 4'h0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'h1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd16_dec(input logic [15:0] y);
        logic [15:0] r;
        logic        b;
        r = y;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'h9;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'h1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A BCD pair is a multiple of 4 when (tens even, ones 0/4/8) or (tens odd, ones 2/6).
    function automatic logic bcd_div4(input logic [7:0] p);
        if (!p[4]) return (p[3:0] == 4'h0) || (p[3:0] == 4'h4) || (p[3:0] == 4'h8);
        return (p[3:0] == 4'h2) || (p[3:0] == 4'h6);
    endfunction

    // Century years are leap only when the century pair itself is a multiple of 4.
    function automatic logic bcd_is_leap(input logic [15:0] y);
        if (y[7:0] == 8'h00) return bcd_div4(y[15:8]);
        return bcd_div4(y[7:0]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] mo, input logic [15:0] y);
        case (mo)
            8'h02:                     return bcd_is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                   return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Divides the board clock to a one-cycle tick every CLK_HZ cycles; clr holds the count at zero.
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned   CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;

    assign tick = !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr)          cnt_q <= '0;
        else if (cnt_q == LAST)  cnt_q <= '0;
        else                     cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD time/date counter with Gregorian leap years and a run/set editing FSM.
// Define BTN_DEC_EN to add a btn_dec input that decrements the selected field.
module bcd_calendar_counter
    import cal_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter logic [15:0] RST_YEAR = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_view,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
`ifdef BTN_DEC_EN
    input  logic        btn_dec,
`endif
    output logic        smh_dmy,
    output logic        dem_chinh,
    output logic [1:0]  blink_led,
    output logic [7:0]  bcd_ss,
    output logic [7:0]  bcd_mm,
    output logic [7:0]  bcd_hh,
    output logic [7:0]  bcd_dd,
    output logic [7:0]  bcd_mo,
    output logic [15:0] bcd_yyyy
);
    mode_e       state_q, state_d;
    logic        view_q, view_d;
    logic [1:0]  blink_q, blink_d;
    logic [7:0]  ss_q, ss_d, mm_q, mm_d, hh_q, hh_d, dd_q, dd_d, mo_q, mo_d;
    logic [15:0] yyyy_q, yyyy_d;
    logic [7:0]  dim_cur, dim_new;
    logic        tick;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == StSet),
        .tick (tick)
    );

    assign dim_cur = days_in_month(mo_q, yyyy_q);

    always_comb begin
        state_d = state_q;
        view_d  = view_q ^ btn_view;
        blink_d = blink_q;
        ss_d    = ss_q;
        mm_d    = mm_q;
        hh_d    = hh_q;
        dd_d    = dd_q;
        mo_d    = mo_q;
        yyyy_d  = yyyy_q;
        case (state_q)
            StRun: begin
                if (btn_mode) begin
                    state_d = StSet;
                    blink_d = FLD_0;
                end else if (tick) begin
                    ss_d = bcd_inc_wrap(ss_q, SEC_MAX, 8'h00);
                    if (ss_q == SEC_MAX) begin
                        mm_d = bcd_inc_wrap(mm_q, SEC_MAX, 8'h00);
                        if (mm_q == SEC_MAX) begin
                            hh_d = bcd_inc_wrap(hh_q, HOUR_MAX, 8'h00);
                            if (hh_q == HOUR_MAX) begin
                                dd_d = bcd_inc_wrap(dd_q, dim_cur, 8'h01);
                                if (dd_q == dim_cur) begin
                                    mo_d = bcd_inc_wrap(mo_q, MON_MAX, 8'h01);
                                    if (mo_q == MON_MAX) yyyy_d = bcd16_inc(yyyy_q);
                                end
                            end
                        end
                    end
                end
            end
            StSet: begin
                if (btn_mode) begin
                    state_d = StRun;
                end else if (btn_sel) begin
                    blink_d = (blink_q == FLD_2) ? FLD_0 : blink_q + 2'd1;
                end else if (btn_inc) begin
                    case ({view_q, blink_q})
                        {1'b0, FLD_0}: ss_d   = bcd_inc_wrap(ss_q, SEC_MAX, 8'h00);
                        {1'b0, FLD_1}: mm_d   = bcd_inc_wrap(mm_q, SEC_MAX, 8'h00);
                        {1'b0, FLD_2}: hh_d   = bcd_inc_wrap(hh_q, HOUR_MAX, 8'h00);
                        {1'b1, FLD_0}: yyyy_d = bcd16_inc(yyyy_q);
                        {1'b1, FLD_1}: mo_d   = bcd_inc_wrap(mo_q, MON_MAX, 8'h01);
                        {1'b1, FLD_2}: dd_d   = bcd_inc_wrap(dd_q, dim_cur, 8'h01);
                        default: ;
                    endcase
`ifdef BTN_DEC_EN
                end else if (btn_dec) begin
                    case ({view_q, blink_q})
                        {1'b0, FLD_0}: ss_d   = bcd_dec_wrap(ss_q, SEC_MAX, 8'h00);
                        {1'b0, FLD_1}: mm_d   = bcd_dec_wrap(mm_q, SEC_MAX, 8'h00);
                        {1'b0, FLD_2}: hh_d   = bcd_dec_wrap(hh_q, HOUR_MAX, 8'h00);
                        {1'b1, FLD_0}: yyyy_d = bcd16_dec(yyyy_q);
                        {1'b1, FLD_1}: mo_d   = bcd_dec_wrap(mo_q, MON_MAX, 8'h01);
                        {1'b1, FLD_2}: dd_d   = bcd_dec_wrap(dd_q, dim_cur, 8'h01);
                        default: ;
                    endcase
`endif
                end
            end
            default: state_d = StRun;
        endcase
        // Month/year edits can shrink the month under the current day.
        dim_new = days_in_month(mo_d, yyyy_d);
        if (dd_d > dim_new) dd_d = dim_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            view_q  <= 1'b0;
            blink_q <= FLD_0;
            ss_q    <= RST_TIME;
            mm_q    <= RST_TIME;
            hh_q    <= RST_TIME;
            dd_q    <= RST_DATE;
            mo_q    <= RST_DATE;
            yyyy_q  <= RST_YEAR;
        end else begin
            state_q <= state_d;
            view_q  <= view_d;
            blink_q <= blink_d;
            ss_q    <= ss_d;
            mm_q    <= mm_d;
            hh_q    <= hh_d;
            dd_q    <= dd_d;
            mo_q    <= mo_d;
            yyyy_q  <= yyyy_d;
        end
    end

    assign smh_dmy   = view_q;
    assign dem_chinh = (state_q == StSet);
    assign blink_led = blink_q;
    assign bcd_ss    = ss_q;
    assign bcd_mm    = mm_q;
    assign bcd_hh    = hh_q;
    assign bcd_dd    = dd_q;
    assign bcd_mo    = mo_q;
    assign bcd_yyyy  = yyyy_q;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Self-checking bench for bcd_calendar_counter with a four-clock second.
module tb_bcd_calendar_counter;
    localparam int unsigned CLK_HZ = 4;

    typedef struct {
        string       name;
        logic [59:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_view = 1'b0, btn_mode = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
    logic        smh_dmy, dem_chinh;
    logic [1:0]  blink_led;
    logic [7:0]  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo;
    logic [15:0] bcd_yyyy;

    exp_t sb[$];
    exp_t e;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bcd_calendar_counter #(.CLK_HZ(CLK_HZ), .RST_YEAR(16'h2000)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_view  (btn_view),
        .btn_mode  (btn_mode),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .smh_dmy   (smh_dmy),
        .dem_chinh (dem_chinh),
        .blink_led (blink_led),
        .bcd_ss    (bcd_ss),
        .bcd_mm    (bcd_mm),
        .bcd_hh    (bcd_hh),
        .bcd_dd    (bcd_dd),
        .bcd_mo    (bcd_mo),
        .bcd_yyyy  (bcd_yyyy)
    );

    // Vector layout: yyyy mo dd hh mm ss, then {smh_dmy, dem_chinh, blink_led} as last nibble.
    function automatic logic [59:0] st(input logic [15:0] y, input logic [7:0] mo,
                                       input logic [7:0] dd, input logic [7:0] hh,
                                       input logic [7:0] mm, input logic [7:0] ss,
                                       input logic smh, input logic dem, input logic [1:0] bl);
        return {y, mo, dd, hh, mm, ss, smh, dem, bl};
    endfunction

    function automatic logic [59:0] obs();
        return {bcd_yyyy, bcd_mo, bcd_dd, bcd_hh, bcd_mm, bcd_ss, smh_dmy, dem_chinh, blink_led};
    endfunction

    task automatic press(input logic v, input logic m, input logic s, input logic i);
        btn_view = v; btn_mode = m; btn_sel = s; btn_inc = i;
        @(negedge clk);
        btn_view = 1'b0; btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // From reset values, enter set mode and dial in a time/date; leaves SET, time view, field 00.
    task automatic load(input int ss, input int mm, input int hh, input int dd, input int mo,
                        input int yyyy);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        inc_n(ss);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        inc_n(mm);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        inc_n(hh);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        inc_n((yyyy - 2000 + 10000) % 10000);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        inc_n(mo - 1);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        inc_n(dd - 1);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.push_back('{"reset state", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 2'b00)});
        repeat (2) @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        rst = 1'b0;
    endtask

    task automatic test_run();
        sb.push_back('{"run before first tick", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0)});
        sb.push_back('{"run first tick", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 0, 0, 0)});
        sb.push_back('{"run 8 cycles", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 0, 0, 0)});
        repeat (3) @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        repeat (4) @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
    endtask

    task automatic test_wrap();
        do_reset();
        load(59, 59, 23, 1, 1, 2000);
        sb.push_back('{"set ss wrap no carry", st(16'h2000, 8'h01, 8'h01, 8'h23, 8'h59, 8'h00, 0, 1, 0)});
        press(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        sb.push_back('{"set mm wrap no carry", st(16'h2000, 8'h01, 8'h01, 8'h23, 8'h00, 8'h00, 0, 1, 1)});
        press(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        sb.push_back('{"set hh wrap no carry", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 2)});
        press(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
    endtask

    task automatic test_rollover();
        do_reset();
        load(59, 59, 23, 31, 12, 2099);
        sb.push_back('{"preload exit", st(16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0, 0, 0)});
        sb.push_back('{"preload hold", st(16'h2099, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 0, 0, 0)});
        sb.push_back('{"century rollover", st(16'h2100, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0)});
        press(1'b0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        repeat (3) @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
    endtask

    task automatic test_leap();
        int          yr[3]  = '{1900, 2000, 2024};
        logic [15:0] yb[3]  = '{16'h1900, 16'h2000, 16'h2024};
        logic [7:0]  edd[3] = '{8'h01, 8'h29, 8'h29};
        logic [7:0]  emo[3] = '{8'h03, 8'h02, 8'h02};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            load(59, 59, 23, 28, 2, yr[i]);
            press(1'b0, 1'b1, 1'b0, 1'b0);
            sb.push_back('{$sformatf("leap day after 28/02/%0d", yr[i]),
                           st(yb[i], emo[i], edd[i], 8'h00, 8'h00, 8'h00, 0, 0, 0)});
            repeat (4) @(negedge clk);
            e = sb.pop_front(); n_total++;
            if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_clamp();
        int          yr[2]  = '{2023, 2024};
        logic [15:0] yb[2]  = '{16'h2023, 16'h2024};
        logic [7:0]  edd[2] = '{8'h28, 8'h29};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            load(0, 0, 0, 31, 1, yr[i]);
            press(1'b1, 1'b0, 1'b0, 1'b0);
            press(1'b0, 1'b0, 1'b1, 1'b0);
            sb.push_back('{$sformatf("day clamp %0d", yr[i]),
                           st(yb[i], 8'h02, edd[i], 8'h00, 8'h00, 8'h00, 1, 1, 1)});
            press(1'b0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front(); n_total++;
            if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) @(negedge clk);
        sb.push_back('{"mode+inc over tick", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0)});
        press(1'b0, 1'b1, 1'b0, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        sb.push_back('{"sel to 01", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 1)});
        press(1'b0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        sb.push_back('{"sel beats inc", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 2)});
        press(1'b0, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        sb.push_back('{"sel wraps to 00", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0)});
        press(1'b0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        sb.push_back('{"inc ss in set", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 0, 1, 0)});
        press(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
    endtask

    task automatic test_set_hold();
        sb.push_back('{"set mode holds ss", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 0, 1, 0)});
        repeat (3 * CLK_HZ) @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        sb.push_back('{"exit set", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 0, 0, 0)});
        sb.push_back('{"no tick before CLK_HZ", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 0, 0, 0)});
        sb.push_back('{"tick at CLK_HZ", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 0, 0, 0)});
        press(1'b0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        repeat (CLK_HZ - 1) @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
    endtask

    task automatic test_view_run();
        sb.push_back('{"view toggle in run", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 1, 0, 0)});
        press(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        sb.push_back('{"sel/inc ignored in run", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 1, 0, 0)});
        press(1'b0, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
    endtask

    task automatic test_reset_mid_edit();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        sb.push_back('{"reset mid edit", st(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0)});
        rst = 1'b1;
        @(negedge clk);
        e = sb.pop_front(); n_total++;
        if (obs() === e.v) n_pass++; else $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_wrap();
        test_rollover();
        test_leap();
        test_clamp();
        test_back_to_back();
        test_set_hold();
        test_view_run();
        test_reset_mid_edit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
